// File: rtl/upuart_ocp_arb_pkg.sv
// Shared OCP encodings and master IDs for the UART OCP arbiter.
package upuart_defs;

   localparam logic [2:0] OCP_CMD_IDLE  = 3'd0;
   localparam logic [2:0] OCP_CMD_WRITE = 3'd1;
   localparam logic [2:0] OCP_CMD_READ  = 3'd2;

   localparam logic [1:0] OCP_RESP_NULL = 2'd0;
   localparam logic [1:0] OCP_RESP_DVA  = 2'd1;
   localparam logic [1:0] OCP_RESP_FAIL = 2'd2;
   localparam logic [1:0] OCP_RESP_ERR  = 2'd3;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

endpackage

// File: rtl/upuart_ocp_rsp_reg.sv
// One-cycle response register: captures the slave response on accept and
// steers it to the owning master only.
module upuart_ocp_rsp_reg
   import upuart_defs::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  accept,
   input  logic                  owner,
   input  logic [1:0]            resp,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [1:0]            s0_resp,
   output logic [DATA_WIDTH-1:0] s0_data,
   output logic [1:0]            s1_resp,
   output logic [DATA_WIDTH-1:0] s1_data
);

   logic                  valid_q;
   logic                  owner_q;
   logic [1:0]            resp_q;
   logic [DATA_WIDTH-1:0] data_q;

   // Reload on every accept, otherwise fall back to NULL/0 after one cycle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         valid_q <= 1'b0;
         owner_q <= M0;
         resp_q  <= OCP_RESP_NULL;
         data_q  <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         owner_q <= owner;
         resp_q  <= resp;
         data_q  <= data;
      end else begin
         valid_q <= 1'b0;
         owner_q <= M0;
         resp_q  <= OCP_RESP_NULL;
         data_q  <= '0;
      end
   end

   // Decode the held response onto the owner's port; the other sees NULL/0.
   always_comb begin
      s0_resp = OCP_RESP_NULL;
      s0_data = '0;
      s1_resp = OCP_RESP_NULL;
      s1_data = '0;
      if (valid_q) begin
         if (owner_q == M0) begin
            s0_resp = resp_q;
            s0_data = data_q;
         end else begin
            s1_resp = resp_q;
            s1_data = data_q;
         end
      end
   end

endmodule

// File: rtl/upuart_ocp_arb.sv
// Two-master round-robin OCP arbiter in front of the UART register slave.
module upuart_ocp_arb
   import upuart_defs::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BEN_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [ADDR_WIDTH-1:0] i_M0Addr,
   input  logic [2:0]            i_M0Cmd,
   input  logic [DATA_WIDTH-1:0] i_M0Data,
   input  logic [BEN_WIDTH-1:0]  i_M0ByteEn,
   output logic                  o_S0CmdAccept,
   output logic [DATA_WIDTH-1:0] o_S0Data,
   output logic [1:0]            o_S0Resp,
   input  logic [ADDR_WIDTH-1:0] i_M1Addr,
   input  logic [2:0]            i_M1Cmd,
   input  logic [DATA_WIDTH-1:0] i_M1Data,
   input  logic [BEN_WIDTH-1:0]  i_M1ByteEn,
   output logic                  o_S1CmdAccept,
   output logic [DATA_WIDTH-1:0] o_S1Data,
   output logic [1:0]            o_S1Resp,
   output logic [ADDR_WIDTH-1:0] o_MAddr,
   output logic [2:0]            o_MCmd,
   output logic [DATA_WIDTH-1:0] o_MData,
   output logic [BEN_WIDTH-1:0]  o_MByteEn,
   input  logic                  i_SCmdAccept,
   input  logic [DATA_WIDTH-1:0] i_SData,
   input  logic [1:0]            i_SResp
);

   logic req0, req1;
   logic sel_valid, sel_id, sel_req, accept;
   logic lock_q, lock_id_q, ptr_q;

   assign req0 = (i_M0Cmd != OCP_CMD_IDLE);
   assign req1 = (i_M1Cmd != OCP_CMD_IDLE);

   // Grant: a stalled command keeps the bus, else sole requester, else pointer.
   always_comb begin
      sel_valid = 1'b0;
      sel_id    = M0;
      if (lock_q) begin
         sel_valid = 1'b1;
         sel_id    = lock_id_q;
      end else if (req0 && req1) begin
         sel_valid = 1'b1;
         sel_id    = ptr_q;
      end else if (req0) begin
         sel_valid = 1'b1;
         sel_id    = M0;
      end else if (req1) begin
         sel_valid = 1'b1;
         sel_id    = M1;
      end
   end

   // Forward the granted master's request to the slave unchanged.
   always_comb begin
      o_MAddr   = '0;
      o_MCmd    = OCP_CMD_IDLE;
      o_MData   = '0;
      o_MByteEn = '0;
      if (sel_valid) begin
         if (sel_id == M0) begin
            o_MAddr   = i_M0Addr;
            o_MCmd    = i_M0Cmd;
            o_MData   = i_M0Data;
            o_MByteEn = i_M0ByteEn;
         end else begin
            o_MAddr   = i_M1Addr;
            o_MCmd    = i_M1Cmd;
            o_MData   = i_M1Data;
            o_MByteEn = i_M1ByteEn;
         end
      end
   end

   // Gate on a real command so a lock on an idled master never accepts.
   assign sel_req       = sel_valid && (o_MCmd != OCP_CMD_IDLE);
   assign accept        = sel_req && i_SCmdAccept;
   assign o_S0CmdAccept = accept && (sel_id == M0);
   assign o_S1CmdAccept = accept && (sel_id == M1);

   // Lock holds the grant while a command stalls; pointer rotates on accept.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         lock_q    <= 1'b0;
         lock_id_q <= M0;
         ptr_q     <= M0;
      end else begin
         lock_q    <= sel_req && !i_SCmdAccept;
         lock_id_q <= sel_id;
         if (accept) begin
            ptr_q <= ~sel_id;
         end
      end
   end

   upuart_ocp_rsp_reg #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rsp_reg (
      .clk     (clk),
      .nrst    (nrst),
      .accept  (accept),
      .owner   (sel_id),
      .resp    (i_SResp),
      .data    (i_SData),
      .s0_resp (o_S0Resp),
      .s0_data (o_S0Data),
      .s1_resp (o_S1Resp),
      .s1_data (o_S1Data)
   );

endmodule

// File: tb/tb_upuart_ocp_arb.sv
// Directed self-checking bench for the two-master UART OCP arbiter.
module tb_upuart_ocp_arb;

   logic        clk;
   logic        nrst;
   logic [31:0] m0_addr, m0_data, m1_addr, m1_data;
   logic [2:0]  m0_cmd, m1_cmd;
   logic [3:0]  m0_ben, m1_ben;
   logic        s0_acc, s1_acc;
   logic [31:0] s0_data, s1_data;
   logic [1:0]  s0_resp, s1_resp;
   logic [31:0] m_addr, m_data;
   logic [2:0]  m_cmd;
   logic [3:0]  m_ben;
   logic        s_acc;
   logic [31:0] s_data;
   logic [1:0]  s_resp;

   int total = 0;
   int bad   = 0;

   upuart_ocp_arb dut (
      .clk           (clk),
      .nrst          (nrst),
      .i_M0Addr      (m0_addr),
      .i_M0Cmd       (m0_cmd),
      .i_M0Data      (m0_data),
      .i_M0ByteEn    (m0_ben),
      .o_S0CmdAccept (s0_acc),
      .o_S0Data      (s0_data),
      .o_S0Resp      (s0_resp),
      .i_M1Addr      (m1_addr),
      .i_M1Cmd       (m1_cmd),
      .i_M1Data      (m1_data),
      .i_M1ByteEn    (m1_ben),
      .o_S1CmdAccept (s1_acc),
      .o_S1Data      (s1_data),
      .o_S1Resp      (s1_resp),
      .o_MAddr       (m_addr),
      .o_MCmd        (m_cmd),
      .o_MData       (m_data),
      .o_MByteEn     (m_ben),
      .i_SCmdAccept  (s_acc),
      .i_SData       (s_data),
      .i_SResp       (s_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_all();
      m0_cmd = 3'd0; m0_addr = '0; m0_data = '0; m0_ben = '0;
      m1_cmd = 3'd0; m1_addr = '0; m1_data = '0; m1_ben = '0;
      s_acc = 1'b0; s_resp = 2'd0; s_data = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_all();
      nrst = 1'b0;
      step();
      step();
      nrst = 1'b1;
   endtask

   initial begin
      int owner, prev;
      idle_all();
      nrst = 1'b0;
      step();
      step();
      @(negedge clk);
      check("rst_s0resp", s0_resp, 2'd0);
      check("rst_s1resp", s1_resp, 2'd0);
      check("rst_s0data", s0_data, 32'h0);
      check("rst_s1data", s1_data, 32'h0);
      check("rst_acc", {s0_acc, s1_acc}, 2'b00);
      check("rst_mcmd", m_cmd, 3'd0);
      step();
      nrst = 1'b1;

      // M0 read alone
      m0_cmd = 3'd2; m0_addr = 32'h8; m0_ben = 4'hf;
      s_acc = 1'b1; s_resp = 2'd1; s_data = 32'h41;
      @(negedge clk);
      check("t1_acc0", s0_acc, 1'b1);
      check("t1_acc1", s1_acc, 1'b0);
      check("t1_maddr", m_addr, 32'h8);
      check("t1_mcmd", m_cmd, 3'd2);
      step();
      idle_all();
      @(negedge clk);
      check("t1_s0resp", s0_resp, 2'd1);
      check("t1_s0data", s0_data, 32'h41);
      check("t1_s1resp", s1_resp, 2'd0);
      step();
      @(negedge clk);
      check("t1_s0resp_clr", s0_resp, 2'd0);
      check("t1_s0data_clr", s0_data, 32'h0);

      // Both masters write every cycle: M0, M1, M0, M1
      do_reset();
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin
            m0_cmd = 3'd1; m0_addr = 32'h4; m0_data = 32'h10; m0_ben = 4'hf;
            m1_cmd = 3'd1; m1_addr = 32'h0; m1_data = 32'h3;  m1_ben = 4'hf;
            s_acc = 1'b1; s_resp = 2'd1; s_data = 32'hA0 + k;
         end else begin
            idle_all();
         end
         @(negedge clk);
         if (k < 4) begin
            owner = k % 2;
            check("t2_maddr", m_addr, (owner == 1) ? 32'h0 : 32'h4);
            check("t2_mdata", m_data, (owner == 1) ? 32'h3 : 32'h10);
            check("t2_acc0", s0_acc, owner == 0);
            check("t2_acc1", s1_acc, owner == 1);
         end
         if (k > 0) begin
            prev = (k - 1) % 2;
            check("t2_own_resp", (prev == 1) ? s1_resp : s0_resp, 2'd1);
            check("t2_own_data", (prev == 1) ? s1_data : s0_data, 32'hA0 + k - 1);
            check("t2_oth_resp", (prev == 1) ? s0_resp : s1_resp, 2'd0);
         end
         step();
      end

      // M1 read stalls 3 cycles, M0 joins, lock holds M1
      do_reset();
      m1_cmd = 3'd2; m1_addr = 32'hC; m1_ben = 4'hf;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) begin
            m0_cmd = 3'd1; m0_addr = 32'h4; m0_data = 32'h77; m0_ben = 4'hf;
         end
         @(negedge clk);
         check("t3_stall_maddr", m_addr, 32'hC);
         check("t3_stall_mcmd", m_cmd, 3'd2);
         check("t3_stall_acc", {s0_acc, s1_acc}, 2'b00);
         step();
      end
      s_acc = 1'b1; s_resp = 2'd1; s_data = 32'h55;
      @(negedge clk);
      check("t3_acc1", s1_acc, 1'b1);
      check("t3_acc0", s0_acc, 1'b0);
      check("t3_maddr", m_addr, 32'hC);
      step();
      m1_addr = 32'h10;
      s_data = 32'h66;
      @(negedge clk);
      check("t3_next_acc0", s0_acc, 1'b1);
      check("t3_next_maddr", m_addr, 32'h4);
      check("t3_s1resp", s1_resp, 2'd1);
      check("t3_s1data", s1_data, 32'h55);
      check("t3_s0resp", s0_resp, 2'd0);
      step();

      // Idle gap does not move the pointer
      do_reset();
      m0_cmd = 3'd2; m0_addr = 32'h8; s_acc = 1'b1; s_resp = 2'd1;
      @(negedge clk);
      check("t4_acc0", s0_acc, 1'b1);
      step();
      idle_all();
      s_acc = 1'b1;
      step();
      step();
      m0_cmd = 3'd1; m0_addr = 32'h4;
      m1_cmd = 3'd1; m1_addr = 32'h18;
      @(negedge clk);
      check("t4_tie_acc1", s1_acc, 1'b1);
      check("t4_tie_acc0", s0_acc, 1'b0);
      check("t4_tie_maddr", m_addr, 32'h18);
      step();

      // Reset in the response cycle drops the response and the pointer
      do_reset();
      m0_cmd = 3'd2; m0_addr = 32'h8; s_acc = 1'b1; s_resp = 2'd1; s_data = 32'h99;
      step();
      idle_all();
      nrst = 1'b0;
      #1;
      check("t5_rst_s0resp", s0_resp, 2'd0);
      check("t5_rst_s0data", s0_data, 32'h0);
      check("t5_rst_s1resp", s1_resp, 2'd0);
      step();
      nrst = 1'b1;
      m0_cmd = 3'd1; m0_addr = 32'h4;
      m1_cmd = 3'd1; m1_addr = 32'h18;
      s_acc = 1'b1; s_resp = 2'd1;
      @(negedge clk);
      check("t5_tie_acc0", s0_acc, 1'b1);
      check("t5_tie_maddr", m_addr, 32'h4);
      step();

      // Slave ERR on M1 read goes to M1 only
      do_reset();
      m1_cmd = 3'd2; m1_addr = 32'h20; s_acc = 1'b1; s_resp = 2'd3; s_data = 32'hDEAD;
      @(negedge clk);
      check("t6_acc1", s1_acc, 1'b1);
      step();
      idle_all();
      @(negedge clk);
      check("t6_s1resp", s1_resp, 2'd3);
      check("t6_s1data", s1_data, 32'hDEAD);
      check("t6_s0resp", s0_resp, 2'd0);
      step();

      // Unknown command is forwarded and can be accepted
      m0_cmd = 3'd5; m0_addr = 32'h2C; m0_ben = 4'h3; s_acc = 1'b1; s_resp = 2'd2;
      @(negedge clk);
      check("t7_mcmd", m_cmd, 3'd5);
      check("t7_mben", m_ben, 4'h3);
      check("t7_acc0", s0_acc, 1'b1);
      step();
      idle_all();
      @(negedge clk);
      check("t7_s0resp", s0_resp, 2'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule
